// File: rtl/mem_to_axi_pkg.sv
// rtl/mem_to_axi_pkg.sv - shared types, LFSR constants and byte-lane flip helper for mem_to_axi
package mem_to_axi_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MAX_BYTS = 64;
  localparam int MAX_W    = MAX_BYTS * 8;

  function automatic logic [MAX_W-1:0] flip_bytes(input logic [MAX_W-1:0] d, input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BYTS; i++) begin
      if (i < n) r[i*8 +: 8] = d[(n-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_to_axi_if.sv
// rtl/mem_to_axi_if.sv - stream interface carrying dat/val/sop/eop/mod with rdy backpressure
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int MOD_W    = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
) ();
  logic [DAT_BYTS*8-1:0] dat;
  logic                  val;
  logic                  sop;
  logic                  eop;
  logic [MOD_W-1:0]      mod;
  logic                  rdy;

  modport source (output dat, val, sop, eop, mod, input rdy);
  modport sink   (input dat, val, sop, eop, mod, output rdy);
  modport master (output dat, val, sop, eop, mod, input rdy);
  modport slave  (input dat, val, sop, eop, mod, output rdy);
endinterface

// File: rtl/mem_to_axi_buf.sv
// rtl/mem_to_axi_buf.sv - 2-entry FIFO with empty bypass; occupancy feeds read credit
module mem_to_axi_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         rd_val,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         push, pop;

  // When empty, incoming data is visible immediately; it is stored only if not consumed now
  assign rd_val = (occ != 2'd0) || wr_en;
  assign rd_dat = (occ != 2'd0) ? mem[rd_ptr] : wr_dat;
  assign pop    = rd_en && (occ != 2'd0);
  assign push   = wr_en && !(rd_en && (occ == 2'd0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/mem_to_axi.sv
// rtl/mem_to_axi.sv - streams a byte-length region of word memory as one stream packet
// Optional pseudo-random forward pressure enabled by defining MEM_TO_AXI_FP_EN.
module mem_to_axi
  import mem_to_axi_pkg::*;
#(
  parameter int DAT_BYTS   = 8,
  parameter int MEM_AW     = 10,
  parameter int LEN_BITS   = 16,
  parameter int FLIP_BYTES = 0,
  parameter int FP         = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [MEM_AW-1:0]     i_base_addr,
  input  logic [LEN_BITS-1:0]   i_len_byts,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_re,
  output logic [MEM_AW-1:0]     o_mem_addr,
  input  logic [DAT_BYTS*8-1:0] i_mem_dat,
  if_axi_stream.source          o_axi
);
  localparam int DW = DAT_BYTS * 8;
  localparam int MW = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;
  localparam int EW = DW + 2 + MW;

  state_t              state, state_nxt;
  logic [LEN_BITS-1:0] rd_left, beats_in;
  logic [LEN_BITS:0]   len_ext;
  logic [MW-1:0]       mod_r, mod_in;
  logic                first_rd, inflight, tag_sop, tag_eop;
  logic [1:0]          occ;
  logic                head_val, show, pop;
  logic [EW-1:0]       wr_ent, head;
  logic [DW-1:0]       word;

  assign len_ext  = {1'b0, i_len_byts} + (LEN_BITS+1)'(DAT_BYTS - 1);
  assign beats_in = LEN_BITS'(len_ext / (LEN_BITS+1)'(DAT_BYTS));
  assign mod_in   = MW'(i_len_byts % LEN_BITS'(DAT_BYTS));

  always_comb begin
    state_nxt = state;
    o_busy    = (state != IDLE);
    o_done    = (state == DONE);
    // Read credit: stored entries plus the read in flight must leave room in the 2-entry FIFO
    o_mem_re  = (state == RUN) && (rd_left != '0) && (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
    case (state)
      IDLE:    if (i_start) state_nxt = (i_len_byts == '0) ? DONE : RUN;
      RUN:     if (o_mem_re && (rd_left == LEN_BITS'(1))) state_nxt = DRAIN;
      DRAIN:   if (pop && head[MW]) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      rd_left    <= '0;
      mod_r      <= '0;
      first_rd   <= 1'b0;
      inflight   <= 1'b0;
      tag_sop    <= 1'b0;
      tag_eop    <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= o_mem_re;
      if (state == IDLE && i_start) begin
        o_mem_addr <= i_base_addr;
        rd_left    <= beats_in;
        mod_r      <= mod_in;
        first_rd   <= 1'b1;
      end else if (o_mem_re) begin
        o_mem_addr <= o_mem_addr + MEM_AW'(1);
        rd_left    <= rd_left - LEN_BITS'(1);
        first_rd   <= 1'b0;
        tag_sop    <= first_rd;
        tag_eop    <= (rd_left == LEN_BITS'(1));
      end
    end
  end

  // Flip first, then blank the unused lanes of a partial last beat
  always_comb begin
    word = (FLIP_BYTES != 0) ? DW'(flip_bytes(MAX_W'(i_mem_dat), DAT_BYTS)) : i_mem_dat;
    if (tag_eop && (mod_r != '0)) begin
      for (int i = 0; i < DAT_BYTS; i++) begin
        if (i >= int'(mod_r)) word[i*8 +: 8] = 8'h00;
      end
    end
  end

  assign wr_ent = {word, tag_sop, tag_eop, tag_eop ? mod_r : {MW{1'b0}}};

  mem_to_axi_buf #(.W(EW)) u_buf (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .wr_en  (inflight),
    .wr_dat (wr_ent),
    .rd_en  (pop),
    .rd_dat (head),
    .rd_val (head_val),
    .occ    (occ)
  );

`ifdef MEM_TO_AXI_FP_EN
  logic [15:0] lfsr;
  logic [31:0] scaled;
  logic        pres;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr <= LFSR_SEED;
      pres <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      pres <= o_axi.val && !o_axi.rdy;
    end
  end

  assign scaled = ({16'd0, lfsr} * 32'd100) >> 16;
  // A beat already on the bus is never withdrawn; only a fresh presentation is gated
  assign show   = head_val && (pres || (scaled >= 32'(FP)));
`else
  assign show   = head_val;
`endif

  assign pop       = o_axi.val && o_axi.rdy;
  assign o_axi.val = show;
  assign o_axi.dat = show ? head[EW-1 -: DW] : '0;
  assign o_axi.sop = show && head[MW+1];
  assign o_axi.eop = show && head[MW];
  assign o_axi.mod = show ? head[MW-1:0] : '0;
endmodule

// File: tb/tb_mem_to_axi.sv
// tb/tb_mem_to_axi.sv - directed self-checking bench for mem_to_axi (plain and byte-flipped instances)
module tb_mem_to_axi;
  localparam int DB = 8;
  localparam int AW = 10;
  localparam int LB = 16;
`ifdef MEM_TO_AXI_FP_EN
  localparam int FPV = 50;
`else
  localparam int FPV = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [LB-1:0] len = '0;
  logic          busy, done, mem_re, f_busy, f_done, f_re;
  logic [AW-1:0] mem_addr, f_addr;
  logic [63:0]   mem_dat, f_mdat;
  logic [63:0]   mem [1024];

  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BYTS(DB)) axi ();
  if_axi_stream #(.DAT_BYTS(DB)) faxi ();

  mem_to_axi #(.DAT_BYTS(DB), .MEM_AW(AW), .LEN_BITS(LB), .FLIP_BYTES(0), .FP(FPV)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base), .i_len_byts(len),
    .o_busy(busy), .o_done(done), .o_mem_re(mem_re), .o_mem_addr(mem_addr),
    .i_mem_dat(mem_dat), .o_axi(axi));

  mem_to_axi #(.DAT_BYTS(DB), .MEM_AW(AW), .LEN_BITS(LB), .FLIP_BYTES(1), .FP(FPV)) dut_flip (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base), .i_len_byts(len),
    .o_busy(f_busy), .o_done(f_done), .o_mem_re(f_re), .o_mem_addr(f_addr),
    .i_mem_dat(f_mdat), .o_axi(faxi));

  always @(posedge clk) begin
    if (mem_re) mem_dat <= mem[mem_addr];
    if (f_re)   f_mdat  <= mem[f_addr];
  end

  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  logic [63:0] q_dat[$];
  logic        q_sop[$];
  logic        q_eop[$];
  logic [2:0]  q_mod[$];
  logic [63:0] f_q[$];
  int          rd_q[$];
  int          n_done = 0, done_cyc = -1, hs_cyc = -1, n_valhi = 0, n_idle = 0;
  int          stall_err = 0, outst = 0, max_out = 0;
  logic        pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0, prst = 1'b1;
  logic [63:0] pd = '0;
  logic [2:0]  pm = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!prst && pv && !pr &&
        (axi.val !== 1'b1 || axi.dat !== pd || axi.sop !== ps || axi.eop !== pe || axi.mod !== pm))
      stall_err++;
    if (mem_re) begin
      rd_q.push_back(int'(mem_addr));
      outst++;
    end
    if (axi.val) n_valhi++;
    if (busy && !axi.val) n_idle++;
    if (axi.val && axi.rdy) begin
      q_dat.push_back(axi.dat);
      q_sop.push_back(axi.sop);
      q_eop.push_back(axi.eop);
      q_mod.push_back(axi.mod);
      hs_cyc = cyc;
      outst--;
    end
    if (outst > max_out) max_out = outst;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (faxi.val && faxi.rdy) f_q.push_back(faxi.dat);
    if (rst) outst = 0;
    pv = axi.val; pr = axi.rdy; pd = axi.dat; ps = axi.sop; pe = axi.eop; pm = axi.mod; prst = rst;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int i);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'((i * 8 + j) & 255);
    return w;
  endfunction

  task automatic clr();
    q_dat.delete(); q_sop.delete(); q_eop.delete(); q_mod.delete(); f_q.delete(); rd_q.delete();
    n_done = 0; done_cyc = -1; hs_cyc = -1; n_valhi = 0; n_idle = 0;
    stall_err = 0; outst = 0; max_out = 0;
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [LB-1:0] l);
    start = 1'b1; base = b; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_done == d0) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_full8(input string tag);
    logic [7:0] sv, ev;
    logic [2:0] mv;
    logic       ok;
    sv = '0; ev = '0; mv = '0; ok = 1'b1;
    check({tag, "_beats"}, 64'(q_dat.size()), 64'd8);
    for (int i = 0; i < q_dat.size() && i < 8; i++) begin
      sv[i] = q_sop[i];
      ev[i] = q_eop[i];
      mv    = mv | q_mod[i];
      if (q_dat[i] !== exp_word(i)) ok = 1'b0;
    end
    check({tag, "_dat_order"}, 64'(ok), 64'd1);
    check({tag, "_sop_mask"}, 64'(sv), 64'h01);
    check({tag, "_eop_mask"}, 64'(ev), 64'h80);
    check({tag, "_mod"}, 64'(mv), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    for (int i = 0; i < 1024; i++) mem[i] = exp_word(i);
    axi.rdy  = 1'b1;
    faxi.rdy = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_val", 64'(axi.val), 64'd0);
    check("rst_dat", axi.dat, 64'd0);
    check("rst_sop_eop_mod", 64'({axi.sop, axi.eop, axi.mod}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two full beats
    clr();
    go(10'd0, 16'd16);
    check("t16_re_c1", 64'(mem_re), 64'd1);
    check("t16_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
`ifndef MEM_TO_AXI_FP_EN
    check("t16_val_c2", 64'(axi.val), 64'd1);
    check("t16_sop_c2", 64'(axi.sop), 64'd1);
`endif
    wait_done("t16", 50);
    check("t16_beats", 64'(q_dat.size()), 64'd2);
    check("t16_dat0", q_dat[0], 64'h0706050403020100);
    check("t16_dat1", q_dat[1], 64'h0F0E0D0C0B0A0908);
    check("t16_sop", 64'({q_sop[0], q_sop[1]}), 64'b10);
    check("t16_eop", 64'({q_eop[0], q_eop[1]}), 64'b01);
    check("t16_mod1", 64'(q_mod[1]), 64'd0);
    check("t16_done_after_hs", 64'(done_cyc), 64'(hs_cyc + 1));
    check("t16_done_cnt", 64'(n_done), 64'd1);
    check("t16_reads", 64'(rd_q.size()), 64'd2);

    // Partial last beat, plain and flipped
    clr();
    go(10'd0, 16'd13);
    wait_done("t13", 50);
    check("t13_beats", 64'(q_dat.size()), 64'd2);
    check("t13_mod1", 64'(q_mod[1]), 64'd5);
    check("t13_eop1", 64'(q_eop[1]), 64'd1);
    check("t13_dat1", q_dat[1], 64'h0000000C0B0A0908);
    check("t13_flip_dat0", f_q[0], 64'h0001020304050607);
    check("t13_flip_dat1", f_q[1], 64'h0000000B0C0D0E0F);

    // Zero length, plus a start while busy
    clr();
    go(10'd0, 16'd0);
    check("t0_busy_c1", 64'(busy), 64'd1);
    check("t0_done_c1", 64'(done), 64'd1);
    start = 1'b1; len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    check("t0_busy_c2", 64'(busy), 64'd0);
    check("t0_done_c2", 64'(done), 64'd0);
    repeat (6) @(negedge clk);
    check("t0_reads", 64'(rd_q.size()), 64'd0);
    check("t0_val_never", 64'(n_valhi), 64'd0);
    check("t0_done_cnt", 64'(n_done), 64'd1);

    // Backpressure pattern with a long stall
    clr();
    go(10'd0, 16'd64);
    axi.rdy = 1'b1; @(negedge clk);
    axi.rdy = 1'b0; @(negedge clk);
    axi.rdy = 1'b1; @(negedge clk);
    axi.rdy = 1'b0; @(negedge clk);
    start = 1'b1; len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    axi.rdy = 1'b1;
    wait_done("t64", 300);
    check_full8("t64");
    check("t64_reads", 64'(rd_q.size()), 64'd8);
    ok = 1'b1;
    for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != i) ok = 1'b0;
    check("t64_rd_order", 64'(ok), 64'd1);
    check("t64_max_outstanding_le2", 64'(max_out <= 2), 64'd1);
    check("t64_stall_stable", 64'(stall_err), 64'd0);

    // Address wrap
    clr();
    go(10'd1023, 16'd24);
    wait_done("twrap", 50);
    check("twrap_reads", 64'(rd_q.size()), 64'd3);
    check("twrap_addr0", 64'(rd_q[0]), 64'd1023);
    check("twrap_addr1", 64'(rd_q[1]), 64'd0);
    check("twrap_addr2", 64'(rd_q[2]), 64'd1);
    check("twrap_dat0", q_dat[0], 64'hFFFEFDFCFBFAF9F8);
    check("twrap_dat2", q_dat[2], 64'h0F0E0D0C0B0A0908);
    check("twrap_eop2_mod", 64'({q_eop[2], q_mod[2]}), 64'b1000);

    // Reset mid-packet, then a clean packet
    clr();
    go(10'd0, 16'd64);
    begin
      int k = 0;
      while (q_dat.size() < 3 && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (q_dat.size() < 3) check("trst_beats_timeout", 64'd0, 64'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("trst_val", 64'(axi.val), 64'd0);
    check("trst_busy", 64'(busy), 64'd0);
    check("trst_mem_re", 64'(mem_re), 64'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("trst_no_done", 64'(n_done), 64'd0);
    clr();
    go(10'd0, 16'd64);
    wait_done("tre", 100);
    check_full8("tre");

`ifdef MEM_TO_AXI_FP_EN
    clr();
    go(10'd0, 16'd8000);
    wait_done("tfp", 6000);
    check("tfp_beats", 64'(q_dat.size()), 64'd1000);
    begin
      int pct;
      pct = (n_idle * 100) / (n_idle + q_dat.size());
      check("tfp_idle_40_60", 64'(pct >= 40 && pct <= 60), 64'd1);
    end
    check("tfp_stall_stable", 64'(stall_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
